network_interface_unit: RTL and testbench
=========================================

// Module: network_interface_unit
// PURPOSE
//  Memory-mapped network interface between the four-stage processor's data-memory port and the
//  local port of a mesh NoC router. Processor writes a 64-bit packet to the output channel buffer;
//  the NIU injects it into the router under a ready/polarity handshake. Packets ejected by the
//  router land in the input channel buffer for the processor to poll and read.
//  Two one-entry buffers, each with a full flag exposed as a status register.
// PARAMETERS
//  DATA_WIDTH  64  packet / processor data width, big-endian bit order [0:DATA_WIDTH-1]
//  ADDR_WIDTH  2   register-select width (4 registers)
// PORTS
//  clk           in   1           clock, all state on posedge
//  reset         in   1           synchronous, active-high
//  addr          in   ADDR_WIDTH  register select from processor
//  d_in          in   DATA_WIDTH  processor write data
//  d_out         out  DATA_WIDTH  processor read data (registered)
//  nicEn         in   1           access strobe
//  nicWrEn       in   1           1=write, 0=read (valid only with nicEn)
//  net_so        out  1           send-out valid to router local input
//  net_ro        in   1           router local input ready
//  net_do        out  DATA_WIDTH  packet to router
//  net_polarity  in   1           router's current VC polarity
//  net_si        in   1           router local output valid
//  net_ri        out  1           NIU ready to accept ejected packet
//  net_di        in   DATA_WIDTH  packet from router
// BEHAVIOUR
//  Reset: in_full=0, out_full=0, both buffers 0, d_out=0; hence net_so=0, net_ri=1, net_do=0.
//  Address map: 0 IN_BUF (R), 1 IN_STATUS (R), 2 OUT_BUF (W), 3 OUT_STATUS (R).
//  Status read value: all zeros except bit [DATA_WIDTH-1] = full flag.
//  Reads: nicEn=1,nicWrEn=0 -> d_out updated at next posedge (1-cycle latency); d_out holds
//   otherwise. Read of addr 2 returns 0. Read of addr 0 returns in_buf and clears in_full at the
//   same edge (destructive read); reading addr 0 while empty returns stale in_buf, no state change.
//  Writes: nicEn=1,nicWrEn=1,addr=2 with out_full=0 -> out_buf<=d_in, out_full<=1.
//   Write while out_full=1 is dropped (buffer unchanged). Writes to addr 0/1/3 ignored.
//  Injection (combinational): net_so = out_full & net_ro & (out_buf[0] == net_polarity);
//   out_buf[0] is the packet VC bit. net_do = out_buf always. When net_so=1, out_full<=0 next edge.
//  Ejection: net_ri = ~in_full (registered flag, no same-cycle bypass).
//   net_si & net_ri -> in_buf<=net_di, in_full<=1 next edge. net_si while full: ignored (router holds).
//  Simultaneous: processor write to addr 2 in the injecting cycle is dropped (out_full still 1);
//   processor read of addr 0 in a cycle with net_si: net_ri is 0, so the read clears in_full and
//   the packet is accepted on the following cycle. Reset dominates all inputs and discards any
//   buffered packet, mid-handshake included.
// STRUCTURE
//  Shared include nic_defs.vh: address localparams (NIC_IN_BUF=0, NIC_IN_STATUS=1,
//   NIC_OUT_BUF=2, NIC_OUT_STATUS=3), VC_BIT=0.
//  Sub-module nic_channel_buffer (DATA_WIDTH): one-entry register + full flag, ports
//   wr_en/wr_data/rd_en/full/data; instantiated twice (input and output channel).
//  Top: address decode, read mux + d_out register, injection/ejection handshake logic.
// TESTING
//  1 Reset 2 cycles -> d_out=0, net_so=0, net_ri=1; read addr 1 and 3 -> 0.
//  2 Write 64'h0000_0000_0000_1234 (VC=0) to addr 2, net_ro=1, polarity=0 -> net_so=1 the cycle
//    after write, net_do=that packet; OUT_STATUS reads 0 afterwards.
//  3 Same packet with polarity=1 for 5 cycles -> net_so=0, OUT_STATUS=1; flip polarity=0 ->
//    injected in 1 cycle; second write while full -> dropped, first packet unchanged.
//  4 net_si=1 with net_di=64'hDEAD_BEEF_0000_0001 -> net_ri=0 next cycle, IN_STATUS=1;
//    second net_si packet held off; read addr 0 -> d_out=DEAD_BEEF_0000_0001 next cycle,
//    net_ri=1 after, held packet accepted following cycle.
//  5 Load both buffers, assert reset mid-handshake -> both flags 0, net_so=0, net_ri=1, d_out=0.

Source files
------------

// File: rtl/network_interface_unit_pkg.sv
// Shared register map and packet-field positions for the network interface unit.
// Register numbers match the processor's data-memory view of the NIU.
package network_interface_unit_pkg;

  typedef enum logic [1:0] {
    NIC_IN_BUF     = 2'd0,
    NIC_IN_STATUS  = 2'd1,
    NIC_OUT_BUF    = 2'd2,
    NIC_OUT_STATUS = 2'd3
  } nic_addr_e;

  // Virtual-channel bit, counted big-endian: index 0 is the packet MSB.
  localparam int VC_BIT = 0;

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry packet register with full flag; write loads and sets full, read clears full.
// Latency 1 cycle; the caller must gate wr_en with ~full and rd_en with full.
// Backpressure: none internally, the full flag is the backpressure signal.
module nic_channel_buffer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (wr_en) begin
      full <= 1'b1;
      data <= wr_data;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/network_interface_unit.sv
// Memory-mapped NIU between the processor data port and the router local port.
// Latency: register reads 1 cycle, injection combinational, ejection 1 cycle.
// Backpressure: net_ri drops while the input buffer is full; writes to a full output buffer drop.
module network_interface_unit
  import network_interface_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di
);

  // Big-endian bit i lives at little-endian index DATA_WIDTH-1-i.
  localparam int VC_POS = DATA_WIDTH - 1 - VC_BIT;

  logic                  in_full, out_full;
  logic [DATA_WIDTH-1:0] in_data, out_data;
  logic                  rd_req, in_rd, in_wr, out_wr;
  logic [DATA_WIDTH-1:0] rd_data;

  assign rd_req = nicEn & ~nicWrEn;
  assign out_wr = nicEn & nicWrEn & (addr == ADDR_WIDTH'(NIC_OUT_BUF)) & ~out_full;
  assign in_rd  = rd_req & (addr == ADDR_WIDTH'(NIC_IN_BUF)) & in_full;
  assign in_wr  = net_si & ~in_full;

  assign net_so = out_full & net_ro & (out_data[VC_POS] == net_polarity);
  assign net_do = out_data;
  assign net_ri = ~in_full;

  nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_in_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_wr),
    .wr_data (net_di),
    .rd_en   (in_rd),
    .full    (in_full),
    .data    (in_data)
  );

  nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (out_wr),
    .wr_data (d_in),
    .rd_en   (net_so),
    .full    (out_full),
    .data    (out_data)
  );

  // Status words carry the flag in big-endian bit DATA_WIDTH-1, i.e. the LSB.
  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_WIDTH'(NIC_IN_BUF):     rd_data = in_data;
      ADDR_WIDTH'(NIC_IN_STATUS):  rd_data[0] = in_full;
      ADDR_WIDTH'(NIC_OUT_STATUS): rd_data[0] = out_full;
      default:                     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_out <= '0;
    end else if (rd_req) begin
      d_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_network_interface_unit.sv
// Scoreboard bench: a transaction-level model predicts every cycle's router-side outputs and
// every read response; a monitor on the falling edge pops and compares.
module tb_network_interface_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out, net_do, net_di;
  logic        nicEn, nicWrEn, net_so, net_ro, net_polarity, net_si, net_ri;

  always #5 clk = ~clk;

  network_interface_unit dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    logic        so;
    logic        ri;
    logic [63:0] dov;
  } st_exp_t;

  rd_exp_t rd_q[$];
  st_exp_t st_q[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  // Reference model: two one-packet mailboxes.
  bit          m_in_full, m_out_full;
  logic [63:0] m_in_buf, m_out_buf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Applies one cycle of stimulus (called at posedge+1) and records what the DUT must show.
  task automatic step(input bit rst, input bit en, input bit wr, input logic [1:0] a,
                      input logic [63:0] din, input bit ro, input bit pol,
                      input bit si, input logic [63:0] di);
    bit          so;
    logic [63:0] v;
    reset = rst; nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_ro = ro; net_polarity = pol; net_si = si; net_di = di;

    so = m_out_full && ro && (m_out_buf[63] == pol);
    st_q.push_back('{cyc, so, !m_in_full, m_out_buf});

    if (rst) begin
      rd_q.push_back('{cyc + 1, 64'd0});
      m_in_full = 0; m_out_full = 0; m_in_buf = '0; m_out_buf = '0;
    end else begin
      if (en && !wr) begin
        case (a)
          2'd0:    v = m_in_buf;
          2'd1:    v = m_in_full ? 64'd1 : 64'd0;
          2'd3:    v = m_out_full ? 64'd1 : 64'd0;
          default: v = 64'd0;
        endcase
        rd_q.push_back('{cyc + 1, v});
      end
      if (so) m_out_full = 0;
      else if (en && wr && a == 2'd2 && !m_out_full) begin
        m_out_full = 1; m_out_buf = din;
      end
      if (en && !wr && a == 2'd0 && m_in_full) m_in_full = 0;
      else if (si && !m_in_full) begin
        m_in_full = 1; m_in_buf = di;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ro, input bit pol);
    step(0, 0, 0, 2'd0, 64'd0, ro, pol, 0, 64'd0);
  endtask

  task automatic rd(input logic [1:0] a, input bit ro, input bit pol, input bit si,
                    input logic [63:0] di);
    step(0, 1, 0, a, 64'd0, ro, pol, si, di);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
        check("st_stale", 64'(st_q[0].cyc), 64'(cyc));
        void'(st_q.pop_front());
      end
      if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
        st_exp_t e;
        e = st_q.pop_front();
        check("net_so", 64'(net_so), 64'(e.so));
        check("net_ri", 64'(net_ri), 64'(e.ri));
        check("net_do", net_do, e.dov);
      end
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        check("rd_stale", 64'(rd_q[0].cyc), 64'(cyc));
        void'(rd_q.pop_front());
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        rd_exp_t r;
        r = rd_q.pop_front();
        check("d_out", d_out, r.val);
      end
    end
  end

  initial begin
    reset = 1; nicEn = 0; nicWrEn = 0; addr = 0; d_in = 0;
    net_ro = 0; net_polarity = 0; net_si = 0; net_di = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d_out", d_out, 64'd0);
    check("rst_net_so", 64'(net_so), 64'd0);
    check("rst_net_ri", 64'(net_ri), 64'd1);
    check("rst_net_do", net_do, 64'd0);
    m_in_full = 0; m_out_full = 0; m_in_buf = '0; m_out_buf = '0;
    mon_en = 1;

    // Status after reset
    rd(2'd1, 0, 0, 0, 0);
    rd(2'd3, 0, 0, 0, 0);

    // VC0 packet injects the cycle after the write
    step(0, 1, 1, 2'd2, 64'h0000_0000_0000_1234, 1, 0, 0, 0);
    idle(1, 0);
    rd(2'd3, 1, 0, 0, 0);
    idle(0, 0);

    // Polarity mismatch holds the packet; second write while full is dropped
    step(0, 1, 1, 2'd2, 64'h0000_0000_0000_1234, 1, 1, 0, 0);
    repeat (4) idle(1, 1);
    rd(2'd3, 1, 1, 0, 0);
    step(0, 1, 1, 2'd2, 64'h0123_4567_89AB_CDEF, 1, 1, 0, 0);
    idle(1, 0);
    idle(1, 0);

    // Ejection, hold-off of a second packet, destructive read
    step(0, 0, 0, 2'd0, 0, 0, 0, 1, 64'hDEAD_BEEF_0000_0001);
    rd(2'd1, 0, 0, 1, 64'h1111_2222_3333_4444);
    rd(2'd0, 0, 0, 1, 64'h1111_2222_3333_4444);
    step(0, 0, 0, 2'd0, 0, 0, 0, 1, 64'h1111_2222_3333_4444);
    rd(2'd0, 0, 0, 0, 0);
    rd(2'd0, 0, 0, 0, 0);
    idle(0, 0);

    // Reset mid-handshake discards both buffers
    step(0, 1, 1, 2'd2, 64'h8000_0000_0000_00AA, 0, 0, 1, 64'h5555_AAAA_5555_AAAA);
    step(1, 1, 1, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 64'h7777_7777_7777_7777);
    idle(1, 1);
    rd(2'd1, 1, 1, 0, 0);
    rd(2'd3, 1, 1, 0, 0);
    idle(0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom_range(0, 9) < 7,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, {$urandom, $urandom});
    end

    idle(0, 0);
    idle(0, 0);
    @(negedge clk);
    #1;
    mon_en = 0;
    check("leftover_expectations", 64'(st_q.size() + rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
